// File: rtl/summator.sv
// Registered two-operand adder/subtractor with carry/borrow, signed overflow and zero flags.
// Define SUMMATOR_SAT_EN to clamp the result to all-ones on add carry and to zero on sub borrow.
module summator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int MSB = WIDTH - 1;

`ifdef SUMMATOR_SAT_EN
  // Unsigned clamp: carry on add pins to all-ones, borrow on sub pins to zero.
  function automatic logic [WIDTH-1:0] saturate(
    input logic [WIDTH-1:0] raw,
    input logic             is_sub,
    input logic             cb
  );
    if (!cb)
      return raw;
    else if (is_sub)
      return '0;
    else
      return '1;
  endfunction
`endif

  function automatic logic signed_ovf(
    input logic signed [WIDTH-1:0] x,
    input logic signed [WIDTH-1:0] y,
    input logic signed [WIDTH-1:0] r,
    input logic                    is_sub
  );
    logic same_sign;
    same_sign = (x[MSB] == y[MSB]);
    return (is_sub ? !same_sign : same_sign) && (r[MSB] != x[MSB]);
  endfunction

  logic        [WIDTH:0]   full_p0;
  logic signed [WIDTH-1:0] a_p0;
  logic signed [WIDTH-1:0] b_p0;
  logic signed [WIDTH-1:0] raw_p0;
  logic        [WIDTH-1:0] res_p0;
  logic                    carry_p0;
  logic                    ovf_p0;
  logic                    zero_p0;

  // Stage p0: combinational arithmetic on the incoming operands.
  always_comb begin
    a_p0     = a;
    b_p0     = b;
    full_p0  = op_sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    raw_p0   = full_p0[WIDTH-1:0];
    carry_p0 = full_p0[WIDTH];
    ovf_p0   = signed_ovf(a_p0, b_p0, raw_p0, op_sub);
`ifdef SUMMATOR_SAT_EN
    res_p0   = saturate(raw_p0, op_sub, carry_p0);
`else
    res_p0   = raw_p0;
`endif
    zero_p0  = (res_p0 == '0);
  end

  logic [WIDTH-1:0] out_p1;
  logic             vld_p1;
  logic             carry_p1;
  logic             ovf_p1;
  logic             zero_p1;

  // Stage p1: result and flags registered; idle cycles hold the last result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_p1   <= '0;
      vld_p1   <= 1'b0;
      carry_p1 <= 1'b0;
      ovf_p1   <= 1'b0;
      zero_p1  <= 1'b1;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        out_p1   <= res_p0;
        carry_p1 <= carry_p0;
        ovf_p1   <= ovf_p0;
        zero_p1  <= zero_p0;
      end
    end
  end

  assign out       = out_p1;
  assign out_valid = vld_p1;
  assign carry     = carry_p1;
  assign overflow  = ovf_p1;
  assign zero      = zero_p1;

endmodule

// File: tb/tb_summator.sv
// Directed testbench for summator: reset, add/sub, wrap, overflow, idle hold, reset mid-stream.
module tb_summator;

`ifdef SUMMATOR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       op_sub;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] out;
  logic       out_valid;
  logic       carry;
  logic       overflow;
  logic       zero;

  int n_checks = 0;
  int n_fail   = 0;

  summator #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op_sub(op_sub),
    .a(a), .b(b), .out(out), .out_valid(out_valid),
    .carry(carry), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_out, input logic e_vld,
                         input logic e_c, input logic e_o, input logic e_z);
    chk({tag, ".out"}, out, e_out);
    chk({tag, ".valid"}, {7'd0, out_valid}, {7'd0, e_vld});
    chk({tag, ".carry"}, {7'd0, carry}, {7'd0, e_c});
    chk({tag, ".ovf"}, {7'd0, overflow}, {7'd0, e_o});
    chk({tag, ".zero"}, {7'd0, zero}, {7'd0, e_z});
  endtask

  task automatic drive(input logic rn, input logic v, input logic s,
                       input logic [7:0] aa, input logic [7:0] bb);
    rst_n    = rn;
    in_valid = v;
    op_sub   = s;
    a        = aa;
    b        = bb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held two cycles with a valid operand pair present.
    drive(1'b0, 1'b1, 1'b0, 8'h55, 8'h01);
    chk_all("rst0", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 8'h55, 8'h01);
    chk_all("rst1", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back adds.
    drive(1'b1, 1'b1, 1'b0, 8'h55, 8'h01);
    chk_all("add55_01", 8'h56, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 8'h55, 8'h05);
    chk_all("add55_05", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 8'h99, 8'h05);
    chk_all("add99_05", 8'h9E, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 8'h80, 8'h10);
    chk_all("add80_10", 8'h90, 1'b1, 1'b0, 1'b0, 1'b0);

    // Wrap / saturation on carry, then an idle cycle holding the flags.
    drive(1'b1, 1'b1, 1'b0, 8'hFF, 8'h01);
    chk_all("addFF_01", SAT ? 8'hFF : 8'h00, 1'b1, 1'b1, 1'b0, SAT ? 1'b0 : 1'b1);
    drive(1'b1, 1'b0, 1'b1, 8'h12, 8'h34);
    chk_all("idle_after_carry", SAT ? 8'hFF : 8'h00, 1'b0, 1'b1, 1'b0, SAT ? 1'b0 : 1'b1);
    drive(1'b1, 1'b1, 1'b0, 8'h7F, 8'h01);
    chk_all("add7F_01", 8'h80, 1'b1, 1'b0, 1'b1, 1'b0);

    // Subtracts.
    drive(1'b1, 1'b1, 1'b1, 8'h55, 8'h05);
    chk_all("sub55_05", 8'h50, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 8'h05, 8'h55);
    chk_all("sub05_55", SAT ? 8'h00 : 8'hB0, 1'b1, 1'b1, 1'b0, SAT ? 1'b1 : 1'b0);
    drive(1'b1, 1'b1, 1'b1, 8'h80, 8'h01);
    chk_all("sub80_01", 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h01);
    chk_all("sub00_01", SAT ? 8'h00 : 8'hFF, 1'b1, 1'b1, 1'b0, SAT ? 1'b1 : 1'b0);

    // Hold while idle with changing and unknown operands.
    drive(1'b1, 1'b1, 1'b0, 8'h55, 8'h01);
    chk_all("hold_setup", 8'h56, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 8'hAA, 8'hBB);
    chk_all("hold0", 8'h56, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'hxx, 8'hxx);
    chk_all("hold1", 8'h56, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'bx, 8'hFF, 8'hxx);
    chk_all("hold2", 8'h56, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset overrides a valid operand on the same edge.
    drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h20);
    chk_all("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 8'h10, 8'h20);
    chk_all("after_rst", 8'h30, 1'b1, 1'b0, 1'b0, 1'b0);

    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/summator.md
Name: summator

Overview:
- Registered two-operand adder/subtractor with status flags, default 8-bit.
- Used as the arithmetic leaf in lab datapaths: operands arrive with a valid strobe, and the result plus flags are presented one clock later.
- Unsigned wrap-around result by default; saturation is optional (see Optional Feature).

Parameters:
- WIDTH, 8, operand and result width in bits (legal range >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- in_valid  input  1  operands and op valid this cycle
- op_sub  input  1  0: out = a + b; 1: out = a - b
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out  output  WIDTH  registered result
- out_valid  output  1  out/flags updated from a valid input on the previous edge
- carry  output  1  add: carry out of MSB; sub: borrow (1 when a < b unsigned)
- overflow  output  1  two's-complement signed overflow of the operation
- zero  output  1  1 when out == 0

Behaviour:
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset: on a rising clk with rst_n=0, out=0, carry=0, overflow=0, zero=1, out_valid=0. Reset overrides in_valid in the same cycle. Reset mid-operation discards the pending result.
- Latency: exactly 1 cycle. If in_valid=1 at edge N, out and flags hold the result after edge N, and out_valid=1 after edge N.
- If in_valid=0 at an edge: out_valid=0 after that edge, and out and the flags hold their previous values.
- Back-to-back operation is supported: in_valid=1 every cycle gives one result per cycle. There is no backpressure.
- Add: full = {1'b0,a} + {1'b0,b} (WIDTH+1 bits); out = full[WIDTH-1:0]; carry = full[WIDTH].
- Sub: full = {1'b0,a} - {1'b0,b}; out = full[WIDTH-1:0]; carry = 1 when a < b (unsigned borrow).
- Overflow, add: a[MSB]==b[MSB] and out[MSB]!=a[MSB].
- Overflow, sub: a[MSB]!=b[MSB] and out[MSB]!=a[MSB].
- zero is computed from the final registered out value, after any saturation.
- Wrap-around without SUMMATOR_SAT_EN: 8'hFF+8'h01 -> out=8'h00, carry=1, zero=1. 8'h00-8'h01 -> out=8'hFF, carry=1.
- Inputs a, b and op_sub are ignored when in_valid=0.
- X on a or b while in_valid=0 must not propagate to the outputs.

Optional Feature:
- Macro: SUMMATOR_SAT_EN.
- Defined: unsigned saturation.
  - Add with carry=1 forces out to all-ones (8'hFF).
  - Sub with borrow forces out to 0.
  - carry and overflow still report the raw, pre-saturation condition; zero reflects the saturated out.
- Undefined: pure modulo-2^WIDTH wrap as specified in Behaviour. No saturation logic is synthesized.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, a=8'h55, b=8'h01 -> out=8'h00, zero=1, carry=0, overflow=0, out_valid=0 throughout.
- Basic adds, op_sub=0, in_valid=1 on consecutive cycles with (55,01), (55,05), (99,05), (80,10) -> out=8'h56, 8'h5A, 8'h9E, 8'h90 on the following cycles. carry=0 for all; overflow=0 for all except 80+10 (0, since signs differ). out_valid=1 each cycle.
- Wrap and overflow: FF+01 -> out=8'h00, carry=1, zero=1, overflow=0. 7F+01 -> out=8'h80, overflow=1, carry=0. With SUMMATOR_SAT_EN, FF+01 -> out=8'hFF, carry=1, zero=0.
- Subtract: 55-05 -> 8'h50, carry=0. 05-55 -> 8'hB0, carry=1 (8'h00 with SUMMATOR_SAT_EN, zero=1). 80-01 -> 8'h7F, overflow=1.
- Hold/idle: a result of 8'h56, then in_valid=0 for 3 cycles while a and b change (including X) -> out stays 8'h56, flags unchanged, out_valid=0.
- Reset mid-stream: in_valid=1 (10+20) with rst_n=0 on the same edge -> out=0, out_valid=0. Next edge with rst_n=1 and 10+20 -> out=8'h30, out_valid=1.
